// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a simple bus datapath.
// Sequences fetch (T0-T2) and execute (T3-T5) for register ALU ops, NOP and halt.
// Ports:
//   Clock, Clear          - clock and synchronous active-high reset
//   IR[31:0], mem_ready   - instruction fields and memory-read handshake
//   out_PC/out_Z_LO/out_MDR, *_in, IncPC, Read - datapath strobes
//   reg_out_en/sel, reg_in_en/sel, alu_op      - register file and ALU controls
//   Run, instr_count      - not-halted flag and completed-instruction counter
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        out_PC,
    output logic        out_Z_LO,
    output logic        out_MDR,
    output logic        MAR_in,
    output logic        PC_in,
    output logic        MDR_in,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        IncPC,
    output logic        Read,
    output logic        reg_out_en,
    output logic [3:0]  reg_out_sel,
    output logic        reg_in_en,
    output logic [3:0]  reg_in_sel,
    output logic [3:0]  alu_op,
    output logic        Run,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr_count;
    logic [15:0] w_count_nxt;
    logic        w_inc;
    logic        w_is_alu;
    logic [3:0]  w_alu_sel;
    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_unused_ir;

    assign w_opcode    = IR[31:27];
    assign w_ra        = IR[26:23];
    assign w_rb        = IR[22:19];
    assign w_rc        = IR[18:15];
    assign w_unused_ir = ^IR[14:0];

    always_comb begin
        w_is_alu  = 1'b1;
        w_alu_sel = 4'd0;
        case (w_opcode)
            5'b00011: w_alu_sel = 4'd1;
            5'b00100: w_alu_sel = 4'd2;
            5'b00101: w_alu_sel = 4'd3;
            5'b00110: w_alu_sel = 4'd4;
            default:  w_is_alu  = 1'b0;
        endcase
    end

    // NOP and halt both complete in T3; ALU ops complete when leaving T5.
    assign w_inc       = ((r_state == S_T3) && !w_is_alu) || (r_state == S_T5);
    assign w_count_nxt = r_instr_count + {15'd0, w_inc};
    assign instr_count = r_instr_count;

    // Counter is written every cycle so it always tracks its own current value.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state       <= S_RST;
            r_instr_count <= 16'd0;
        end else begin
            r_state       <= w_next;
            r_instr_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = mem_ready ? S_T2 : S_T1;
            S_T2:   w_next = S_T3;
            S_T3: begin
                if (w_is_alu)
                    w_next = S_T4;
                else if (w_opcode == OP_HALT)
                    w_next = S_HALT;
                else
                    w_next = S_T0;
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = S_T0;
            S_HALT: w_next = S_HALT;
        endcase
    end

    always_comb begin
        out_PC      = 1'b0;
        out_Z_LO    = 1'b0;
        out_MDR     = 1'b0;
        MAR_in      = 1'b0;
        PC_in       = 1'b0;
        MDR_in      = 1'b0;
        IR_in       = 1'b0;
        Y_in        = 1'b0;
        Z_in        = 1'b0;
        IncPC       = 1'b0;
        Read        = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = 4'd0;
        reg_in_en   = 1'b0;
        reg_in_sel  = 4'd0;
        alu_op      = 4'd0;
        Run         = 1'b1;
        case (r_state)
            S_RST: ;
            S_T0: begin
                out_PC = 1'b1;
                MAR_in = 1'b1;
                IncPC  = 1'b1;
                Z_in   = 1'b1;
            end
            S_T1: begin
                out_Z_LO = 1'b1;
                Read     = 1'b1;
                MDR_in   = 1'b1;
                PC_in    = mem_ready;
            end
            S_T2: begin
                out_MDR = 1'b1;
                IR_in   = 1'b1;
            end
            S_T3: begin
                if (w_is_alu) begin
                    reg_out_en  = 1'b1;
                    reg_out_sel = w_rb;
                    Y_in        = 1'b1;
                end
            end
            S_T4: begin
                reg_out_en  = 1'b1;
                reg_out_sel = w_rc;
                alu_op      = w_alu_sel;
                Z_in        = 1'b1;
            end
            S_T5: begin
                out_Z_LO   = 1'b1;
                reg_in_en  = 1'b1;
                reg_in_sel = w_ra;
            end
            S_HALT: Run = 1'b0;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Clear  input  1  synchronous, active-high reset.
REQ-003 IR  input  32  instruction register contents from datapath; fields: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
REQ-004 mem_ready  input  1  memory read complete; sampled only in T1.
REQ-005 out_PC, out_Z_LO, out_MDR  output  1 each  bus drive enables to datapath.
REQ-006 MAR_in, PC_in, MDR_in, IR_in, Y_in, Z_in  output  1 each  register load enables to datapath.
REQ-007 IncPC, Read  output  1 each  PC-increment ALU select; memory read strobe.
REQ-008 reg_out_en  output  1  general register drives bus; reg_out_sel  output  4  register index.
REQ-009 reg_in_en  output  1  general register load; reg_in_sel  output  4  register index.
REQ-010 alu_op  output  4  0=none, 1=add, 2=sub, 3=and, 4=or.
REQ-011 Run  output  1  high while not halted.
REQ-012 instr_count  output  16  completed-instruction counter.

Function
REQ-013 States SHALL be RST, T0, T1, T2, T3, T4, T5, HALT; control outputs are Moore decode of state (plus IR fields in T3-T5, mem_ready in T1); outputs not listed for a state are 0.
REQ-014 RST: all control outputs 0, Run=1; next T0.
REQ-015 T0: out_PC, MAR_in, IncPC, Z_in = 1; next T1.
REQ-016 T1: out_Z_LO, Read, MDR_in = 1; remain in T1 while mem_ready=0; PC_in = 1 only in the cycle mem_ready=1; next T2 on that cycle.
REQ-017 T2: out_MDR, IR_in = 1; next T3 (IR valid from T3 onward).
REQ-018 T3 decode: opcode 00011 add, 00100 sub, 00101 and, 00110 or -> reg_out_en=1, reg_out_sel=rb, Y_in=1, next T4.
REQ-019 T3, opcode 11011 (halt): no outputs asserted, next HALT.
REQ-020 T3, any other opcode: treated as NOP, no outputs asserted, instr_count incremented, next T0.
REQ-021 T4: reg_out_en=1, reg_out_sel=rc, alu_op per opcode (add=1, sub=2, and=3, or=4), Z_in=1; next T5.
REQ-022 T5: out_Z_LO=1, reg_in_en=1, reg_in_sel=ra; instr_count increments on exit; next T0.
REQ-023 HALT: all control outputs 0, Run=0; remains in HALT until Clear; instr_count increments once on entry.
REQ-024 instr_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-025 ALU instruction latency SHALL be 6 cycles with mem_ready=1 in first T1 cycle, plus one cycle per T1 wait cycle.
REQ-026 ra = rb = rc permitted; no hazard checking; reg_in_sel=0 is driven unchanged.

Reset
REQ-027 Clear=1 at a rising edge SHALL force state RST, instr_count=0, all control outputs 0 and Run=1 in the following cycle, regardless of current state including HALT and T1 wait.
REQ-028 Clear mid-instruction SHALL abandon it without incrementing instr_count; Clear has priority over all transitions.

Verification
REQ-029 Clear, then mem_ready=1, IR=0x28918000 -> T0..T5 sequence; T3 reg_out_sel=2, Y_in=1; T4 reg_out_sel=3, alu_op=3, Z_in=1; T5 reg_in_sel=1, reg_in_en=1; instr_count=1.
REQ-030 mem_ready held 0 for 3 cycles in T1 -> Read/MDR_in high 4 cycles, PC_in high only in 4th; total latency 9 cycles.
REQ-031 IR opcode 11011 -> HALT after T3, Run=0 held 20 cycles, instr_count=1; Clear -> Run=1, count=0, fetch resumes.
REQ-032 IR opcode 11111 -> T3 returns to T0, no reg/ALU strobes, instr_count=1 after 4 cycles.
REQ-033 Clear asserted in T4 -> next cycle RST, all outputs 0, instr_count=0, next T0.
REQ-034 instr_count preset via 65535 NOP instructions then one more -> instr_count=0x0000.
